// File: rtl/imem_fetch_pkg.sv
// Shared definitions for the instruction-fetch block (package fetch_pkg).
// Holds the memory read/write encodings, the default memory window, the
// fetch state encoding, the instruction word type and a window helper.
package fetch_pkg;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    localparam logic [31:0] DEFAULT_STARTING_ADDR   = 32'h0100_0000;
    localparam logic [31:0] DEFAULT_MEM_DEPTH_BYTES = 32'h0010_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DONE  = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    typedef logic [31:0] inst_word_t;

    // True when addr lies in [base, base+depth). The subtraction wraps modulo
    // 2^32, so an address below base becomes huge and fails the compare.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] depth);
        return (addr - base) < depth;
    endfunction

endpackage

// File: rtl/imem_fetch_if.sv
// Bus bundle between the fetch unit (master), main memory, decode and the
// redirect source. The master modport is the fetch unit's view.
interface imem_fetch_if;
    import fetch_pkg::*;

    logic [31:0] mem_address;
    logic        mem_read_write;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        inst_valid;
    logic        inst_ready;
    inst_word_t  inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_done;
    logic        fetch_fault;

    modport master (
        output mem_address, mem_read_write, mem_data_in,
        input  mem_data_out,
        output inst_valid, inst, inst_pc,
        input  inst_ready,
        input  redirect_valid, redirect_pc,
        output fetch_done, fetch_fault
    );

    modport slave (
        input  mem_address, mem_read_write, mem_data_in,
        output mem_data_out,
        input  inst_valid, inst, inst_pc,
        output inst_ready,
        output redirect_valid, redirect_pc,
        input  fetch_done, fetch_fault
    );

endinterface

// File: rtl/fetch_out_reg.sv
// One-entry valid/ready output register for fetched instructions.
// flush wins over load, load wins over a plain consume.
module fetch_out_reg
    import fetch_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic        ready,
    input  inst_word_t  inst_in,
    input  logic [31:0] pc_in,
    output logic        valid,
    output inst_word_t  inst,
    output logic [31:0] inst_pc
);

    logic        valid_q, valid_d;
    inst_word_t  inst_q, inst_d;
    logic [31:0] pc_q, pc_d;

    // Next-state of the holding register: flush, load a new word, or drop a consumed one.
    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            inst_d  = inst_in;
            pc_d    = pc_in;
        end else if (ready) begin
            valid_d = 1'b0;
        end
    end

    // Holding register with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign valid   = valid_q;
    assign inst    = inst_q;
    assign inst_pc = pc_q;

endmodule

// File: rtl/imem_fetch.sv
// Instruction-fetch initiator: keeps a word-aligned fetch PC, reads main
// memory combinationally at that PC and registers one word per cycle into a
// valid/ready output stage. Redirects flush and reload the PC; fetching stops
// once the PC leaves the memory window.
// Optional feature macro FETCH_ALIGN_CHECK_EN: misaligned or out-of-window
// redirects enter a sticky FAULT state instead of being silently aligned.
module imem_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] STARTING_ADDR   = DEFAULT_STARTING_ADDR,
    parameter logic [31:0] MEM_DEPTH_BYTES = DEFAULT_MEM_DEPTH_BYTES
)(
    input logic          clock,
    input logic          reset,
    imem_fetch_if.master bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc_plus4;
    logic [31:0]  redirect_aligned;
    logic         redirect_bad;
    logic         load;
    logic         flush;
    logic         inst_valid;

    assign pc_plus4         = pc_q + 32'd4;
    assign redirect_aligned = bus.redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_bad = (bus.redirect_pc[1:0] != 2'b00) ||
                          !in_window(bus.redirect_pc, STARTING_ADDR, MEM_DEPTH_BYTES);
`else
    assign redirect_bad = 1'b0;
`endif

    // Next state, next PC and output-register controls; redirect outranks loads.
    // The window-end test is "next PC outside the window": for in-window PCs this
    // is exactly pc+4 == end, and an out-of-window PC stops after one fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        load    = 1'b0;
        flush   = 1'b0;
        if (state_q == FAULT) begin
            flush = 1'b1;
        end else if (bus.redirect_valid) begin
            flush = 1'b1;
            if (redirect_bad) begin
                state_d = FAULT;
            end else begin
                state_d = FETCH;
                pc_d    = redirect_aligned;
            end
        end else if ((state_q == FETCH) && (!inst_valid || bus.inst_ready)) begin
            load = 1'b1;
            pc_d = pc_plus4;
            if (!in_window(pc_plus4, STARTING_ADDR, MEM_DEPTH_BYTES)) begin
                state_d = DONE;
            end
        end
    end

    // FSM state and fetch PC with asynchronous reset to the window base.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= STARTING_ADDR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_out_reg u_out_reg (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .flush   (flush),
        .ready   (bus.inst_ready),
        .inst_in (bus.mem_data_out),
        .pc_in   (pc_q),
        .valid   (inst_valid),
        .inst    (bus.inst),
        .inst_pc (bus.inst_pc)
    );

    assign bus.inst_valid     = inst_valid;
    assign bus.mem_address    = pc_q;
    assign bus.mem_read_write = READ;
    assign bus.mem_data_in    = 32'd0;
    assign bus.fetch_done     = (state_q == DONE);
    assign bus.fetch_fault    = (state_q == FAULT);

endmodule

// File: doc/imem_fetch.md
# imem_fetch

Instruction-fetch initiator that drives the main memory's address/read_write port and streams fetched 32-bit words to decode over a valid/ready handshake. It sits between the core's control path (redirects) and the byte-addressed, little-endian main memory, whose read data is combinational on the address. The block keeps a word-aligned fetch PC, registers one instruction per cycle, stalls on back-pressure, flushes on redirect, and stops at the end of the memory window.

## Interface
Parameters:
- STARTING_ADDR, 'h01000000, first fetch address and base of the memory window
- MEM_DEPTH_BYTES, 'h0100000, size of the memory window in bytes

Ports:
- clock  input  1  single clock; all state updates on posedge
- reset  input  1  asynchronous, active-high
- mem_address  output  32  byte address to main memory; always equals the fetch PC
- mem_read_write  output  1  tied to READ (0)
- mem_data_in  output  32  tied to 0
- mem_data_out  input  32  combinational read data from main memory for mem_address
- inst_valid  output  1  inst/inst_pc hold a fetched word
- inst_ready  input  1  decode accepts the word this cycle
- inst  output  32  fetched instruction word
- inst_pc  output  32  address of inst
- redirect_valid  input  1  load a new fetch PC this cycle
- redirect_pc  input  32  new fetch PC
- fetch_done  output  1  fetch PC left the window; no further fetches
- fetch_fault  output  1  illegal redirect detected (only with FETCH_ALIGN_CHECK_EN)

## Operation
- State machine: FETCH, DONE, FAULT. Reset enters FETCH.
- Output register is loaded when `load = (state==FETCH) && (!inst_valid || inst_ready) && !redirect_valid`.
- On load: inst <= mem_data_out, inst_pc <= pc, inst_valid <= 1, pc <= pc + 4.
- Stall when inst_valid && !inst_ready: pc, mem_address, inst, inst_pc, inst_valid all hold.
- Consume without reload (inst_ready && inst_valid && state!=FETCH): inst_valid <= 0.
- Redirect (highest priority, any state except FAULT): pc <= redirect_pc with [1:0] cleared, inst_valid <= 0 (flush, including any word offered the same cycle), state <= FETCH, and fetch_done clears.
- Window end: a load with pc + 4 == STARTING_ADDR + MEM_DEPTH_BYTES moves to DONE. The last word stays valid until consumed.
- DONE: no loads. fetch_done = 1. Only a redirect or reset leaves it.
- Arithmetic: 32-bit modulo-2^32 addition. pc[1:0] is always 0.

## Timing
- Reset values: pc = STARTING_ADDR, mem_address = STARTING_ADDR, mem_read_write = 0, mem_data_in = 0, inst_valid = 0, inst = 0, inst_pc = 0, fetch_done = 0, fetch_fault = 0, state = FETCH.
- Latency: the word at address A is on inst one cycle after pc == A. Throughput is one word per cycle with inst_ready held high.
- mem_address is a register output and changes only on a clock edge.
- Reset asserted mid-stream: all outputs return to reset values immediately, without waiting for a clock edge.
- Redirect and inst_ready in the same cycle: the handshake completes for the current word, and the flush applies to the next word.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0] != 0, or with redirect_pc outside [STARTING_ADDR, STARTING_ADDR+MEM_DEPTH_BYTES), enters FAULT.
  - In FAULT: fetch_fault = 1 (sticky), inst_valid <= 0, no loads, and further redirects are ignored. Only reset exits.
- FETCH_ALIGN_CHECK_EN undefined:
  - redirect_pc[1:0] is silently cleared and no range check is made.
  - fetch_fault is tied 0 and FAULT is unreachable.
  - An out-of-window redirect then reaches DONE after one fetch. This is the pc + 4 window-end rule; the fetch itself reads outside the window.

## Structure
- Shared package fetch_pkg: READ/WRITE encodings (0/1), default STARTING_ADDR and MEM_DEPTH_BYTES, fetch state enum, and an instruction-word typedef (32 bits).
- One sub-module, fetch_out_reg: a one-entry valid/ready output register with load/flush inputs, holding inst/inst_pc/inst_valid. The FSM and PC counter stay in imem_fetch.

## Test plan
- Reset, memory preloaded with words W0..W3 at 'h01000000.., inst_ready = 1: inst_pc = 'h01000000, 'h01000004, … on consecutive cycles, with inst = W0, W1, ….
- inst_ready held low for 3 cycles after the first word: inst = W0 and mem_address = 'h01000004 both stable for 3 cycles. W1 appears the cycle after inst_ready rises.
- redirect_valid with redirect_pc = 'h01000040 while W2 is offered: inst_valid = 0 next cycle, then inst_pc = 'h01000040. No W2 or W3 appears after the flush.
- Redirect to 'h010FFFF8: two words delivered, then fetch_done = 1 and no further valid. A redirect to 'h01000000 clears fetch_done and restarts fetch.
- With FETCH_ALIGN_CHECK_EN: redirect_pc = 'h01000002 gives fetch_fault = 1 and inst_valid = 0 permanently. Reset clears both.
- Without the macro: the same redirect fetches from 'h01000000.
- Reset pulse between clock edges mid-stream: inst_valid drops immediately and mem_address = 'h01000000 before the next edge.
